cmd_cntrl: RTL and testbench

Command controller for the follow-me robot. It takes 8-bit commands from the UART/BLE receive path and 8-bit station IDs from the IR/ID receiver, and tracks a STOP/GO state with a latched destination ID. It tells the motion logic when to move (`go`, `in_transit`), and drives a piezo buzzer when the robot is in transit but motion is blocked. It sits between the command receiver, the ID receiver and the motion controller.

---
 rtl/cmd_cntrl.sv | 112 +++++++++++
 tb/tb_cmd_cntrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cntrl.sv
// Command controller: STOP/GO tracking with a latched destination station ID and a piezo alarm.
// Optional buzzer counter is built only when CMD_CNTRL_BUZZ_EN is defined; otherwise buzz is tied low.
module cmd_cntrl #(
    parameter int BUZZ_HALF_PERIOD = 6250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    input  logic       OK2Move,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_cmd_rdy,
    output logic       clr_ID_vld,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n
);

    typedef enum logic {
        STOP = 1'b0,
        GO   = 1'b1
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    state_t     state_q, state_d;
    logic [5:0] dest_id_q, dest_id_d;
    logic [1:0] unused_id_hi;

    assign unused_id_hi = ID[7:6];

    // A pending command always wins; the ID is left pending for the following cycle.
    always_comb begin
        state_d     = state_q;
        dest_id_d   = dest_id_q;
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = 1'b0;
        if (cmd_rdy) begin
            if (cmd[7:6] == OP_GO) begin
                state_d   = GO;
                dest_id_d = cmd[5:0];
            end else if (cmd[7:6] == OP_STOP) begin
                state_d = STOP;
            end
        end else if (ID_vld) begin
            clr_ID_vld = 1'b1;
            if ((state_q == GO) && (ID[5:0] == dest_id_q)) begin
                state_d = STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= STOP;
            dest_id_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            dest_id_q <= dest_id_d;
        end
    end

    assign in_transit = (state_q == GO);
    assign go         = in_transit & OK2Move;

`ifdef CMD_CNTRL_BUZZ_EN
    localparam int CNT_W = $clog2(BUZZ_HALF_PERIOD);

    logic [CNT_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic             buzz_q, buzz_d;
    logic             buzz_en;

    // Square wave only while the robot wants to move but is blocked.
    always_comb begin
        buzz_en    = in_transit & ~OK2Move;
        buzz_cnt_d = buzz_cnt_q;
        buzz_d     = buzz_q;
        if (!buzz_en) begin
            buzz_cnt_d = '0;
            buzz_d     = 1'b0;
        end else if (buzz_cnt_q == CNT_W'(BUZZ_HALF_PERIOD - 1)) begin
            buzz_cnt_d = '0;
            buzz_d     = ~buzz_q;
        end else begin
            buzz_cnt_d = buzz_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else begin
            buzz_cnt_q <= buzz_cnt_d;
            buzz_q     <= buzz_d;
        end
    end

    assign buzz = buzz_q;
`else
    logic [31:0] unused_half_period;

    assign unused_half_period = BUZZ_HALF_PERIOD;
    assign buzz               = 1'b0;
`endif

    assign buzz_n = ~buzz;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Randomised and directed bench for cmd_cntrl against a cycle-level reference model.
module tb_cmd_cntrl;

    localparam int HP = 4;
`ifdef CMD_CNTRL_BUZZ_EN
    localparam bit BUZZ_ON = 1'b1;
`else
    localparam bit BUZZ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       cmd_rdy = 1'b0;
    logic       ok2move = 1'b0;
    logic [7:0] id = 8'h00;
    logic       id_vld = 1'b0;
    logic       clr_cmd_rdy, clr_id_vld, in_transit, go, buzz, buzz_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: moving flag, destination, and count of consecutive enabled cycles.
    bit       m_go   = 1'b0;
    bit [5:0] m_dest = 6'd0;
    int       m_k    = 0;

    cmd_cntrl #(.BUZZ_HALF_PERIOD(HP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .OK2Move    (ok2move),
        .ID         (id),
        .ID_vld     (id_vld),
        .clr_cmd_rdy(clr_cmd_rdy),
        .clr_ID_vld (clr_id_vld),
        .in_transit (in_transit),
        .go         (go),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    function automatic logic exp_buzz();
        return BUZZ_ON ? logic'((m_k / HP) % 2) : 1'b0;
    endfunction

    task automatic apply_inputs(input logic r, input logic [7:0] c, input logic cr,
                                input logic ok, input logic [7:0] i, input logic iv);
        rst_n   = r;
        cmd     = c;
        cmd_rdy = cr;
        ok2move = ok;
        id      = i;
        id_vld  = iv;
        #1;
    endtask

    task automatic tick();
        bit en;
        @(posedge clk);
        en = m_go && !ok2move;
        if (rst_n) begin
            m_go   = 1'b0;
            m_dest = 6'd0;
            m_k    = 0;
        end else begin
            if (cmd_rdy) begin
                if (cmd[7:6] == 2'b01) begin
                    m_go   = 1'b1;
                    m_dest = cmd[5:0];
                end else if (cmd[7:6] == 2'b00) begin
                    m_go = 1'b0;
                end
            end else if (id_vld && m_go && (id[5:0] == m_dest)) begin
                m_go = 1'b0;
            end
            m_k = en ? m_k + 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        apply_inputs(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
        n_tests++;
        if (clr_cmd_rdy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_clr_cmd: got %b expected 1", clr_cmd_rdy);
        end
        n_tests++;
        if (clr_id_vld !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_clr_id: got %b expected 0", clr_id_vld);
        end
        tick();
        n_tests++;
        if ({in_transit, go, buzz, buzz_n} !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected 0001", {in_transit, go, buzz, buzz_n});
        end
    endtask

    task automatic test_ignored_cmd();
        apply_inputs(1'b0, 8'hD7, 1'b1, 1'b1, 8'h00, 1'b0);
        n_tests++;
        if (clr_cmd_rdy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL ignored_clr_cmd: got %b expected 1", clr_cmd_rdy);
        end
        tick();
        n_tests++;
        if (in_transit !== 1'b0) begin
            n_fail++; $display("[TB] FAIL ignored_state: got %b expected 0", in_transit);
        end
    endtask

    task automatic test_go_cmd();
        apply_inputs(1'b0, 8'h73, 1'b1, 1'b1, 8'h00, 1'b0);
        n_tests++;
        if (in_transit !== 1'b0) begin
            n_fail++; $display("[TB] FAIL go_latency: got %b expected 0", in_transit);
        end
        tick();
        n_tests++;
        if ({in_transit, go} !== 2'b11) begin
            n_fail++; $display("[TB] FAIL go_cmd: got %b expected 11", {in_transit, go});
        end
        apply_inputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++;
        if (go !== 1'b0) begin
            n_fail++; $display("[TB] FAIL go_comb: got %b expected 0", go);
        end
        apply_inputs(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
    endtask

    task automatic test_id_mismatch();
        apply_inputs(1'b0, 8'h00, 1'b0, 1'b1, 8'h49, 1'b1);
        n_tests++;
        if ({clr_cmd_rdy, clr_id_vld} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL mismatch_clr: got %b expected 01", {clr_cmd_rdy, clr_id_vld});
        end
        tick();
        n_tests++;
        if (in_transit !== 1'b1) begin
            n_fail++; $display("[TB] FAIL mismatch_state: got %b expected 1", in_transit);
        end
    endtask

    task automatic test_simultaneous();
        apply_inputs(1'b0, 8'h49, 1'b1, 1'b1, 8'h09, 1'b1);
        n_tests++;
        if ({clr_cmd_rdy, clr_id_vld} !== 2'b10) begin
            n_fail++; $display("[TB] FAIL simul_clr: got %b expected 10", {clr_cmd_rdy, clr_id_vld});
        end
        tick();
        n_tests++;
        if (in_transit !== 1'b1) begin
            n_fail++; $display("[TB] FAIL simul_state: got %b expected 1", in_transit);
        end
        apply_inputs(1'b0, 8'h49, 1'b0, 1'b1, 8'h09, 1'b1);
        n_tests++;
        if ({clr_cmd_rdy, clr_id_vld} !== 2'b01) begin
            n_fail++; $display("[TB] FAIL simul_id_clr: got %b expected 01", {clr_cmd_rdy, clr_id_vld});
        end
        tick();
        n_tests++;
        if (in_transit !== 1'b0) begin
            n_fail++; $display("[TB] FAIL simul_match: got %b expected 0", in_transit);
        end
    endtask

    task automatic test_buzzer();
        apply_inputs(1'b0, 8'h73, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 3 * HP; i++) begin
            apply_inputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            n_tests++;
            if (go !== 1'b0) begin
                n_fail++; $display("[TB] FAIL buzz_go: got %b expected 0", go);
            end
            tick();
            n_tests++;
            if ({buzz, buzz_n} !== {exp_buzz(), ~exp_buzz()}) begin
                n_fail++;
                $display("[TB] FAIL buzz_wave[%0d]: got %b expected %b", i, {buzz, buzz_n},
                         {exp_buzz(), ~exp_buzz()});
            end
        end
        apply_inputs(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        n_tests++;
        if ({go, buzz, buzz_n} !== 3'b101) begin
            n_fail++; $display("[TB] FAIL buzz_clear: got %b expected 101", {go, buzz, buzz_n});
        end
    endtask

    task automatic test_reset_mid_transit();
        for (int i = 0; i < HP + 1; i++) begin
            apply_inputs(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        n_tests++;
        if (buzz !== exp_buzz()) begin
            n_fail++; $display("[TB] FAIL pre_reset_buzz: got %b expected %b", buzz, exp_buzz());
        end
        apply_inputs(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        n_tests++;
        if ({in_transit, buzz, buzz_n} !== 3'b001) begin
            n_fail++; $display("[TB] FAIL reset_transit: got %b expected 001", {in_transit, buzz, buzz_n});
        end
    endtask

    task automatic test_random();
        logic       r, cr, ok, iv;
        logic [7:0] c, i;
        ok = 1'b1;
        for (int n = 0; n < 500; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            cr = ($urandom_range(0, 2) == 0);
            c  = 8'($urandom);
            c[5:0] = 6'($urandom_range(0, 3));
            i  = 8'($urandom);
            i[5:0] = 6'($urandom_range(0, 3));
            iv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ok = ~ok;
            apply_inputs(r, c, cr, ok, i, iv);
            n_tests++;
            if ({clr_cmd_rdy, clr_id_vld, go} !== {cr, ~cr & iv, logic'(m_go) & ok}) begin
                n_fail++;
                $display("[TB] FAIL rand_comb[%0d]: got %b expected %b", n, {clr_cmd_rdy, clr_id_vld, go},
                         {cr, ~cr & iv, logic'(m_go) & ok});
            end
            tick();
            n_tests++;
            if ({in_transit, buzz, buzz_n} !== {logic'(m_go), exp_buzz(), ~exp_buzz()}) begin
                n_fail++;
                $display("[TB] FAIL rand_state[%0d]: got %b expected %b", n, {in_transit, buzz, buzz_n},
                         {logic'(m_go), exp_buzz(), ~exp_buzz()});
            end
        end
    endtask

    initial begin
        test_reset();
        test_ignored_cmd();
        test_go_cmd();
        test_id_mismatch();
        test_simultaneous();
        test_buzzer();
        test_reset_mid_transit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
